// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {instruction, pc} pairs between
// instruction memory and the decoder. Latency: 1 cycle push-to-head, no bypass.
// Backpressure: in_ready drops while full; a push offered while full is ignored.
//
// Ports:
//   clk, reset                         - single clock, async active-high reset
//   in_valid/in_ready                  - push handshake from instruction memory
//   in_instruction, in_pc              - fetched word and the PC it came from
//   out_valid/out_ready                - pop handshake to the decoder
//   out_instruction, out_pc            - head entry, forced to 0 while empty
//   flush                              - drop every entry (jump/return taken)
//   count, full, empty                 - occupancy status
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_instruction,
  input  logic [WIDTH-1:0]         in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instruction,
  output logic [WIDTH-1:0]         out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] instruction;
    logic [WIDTH-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  entry_t        head;

  // Status is decoded from count alone, so an asynchronous reset clearing
  // count immediately shows an empty, ready queue without waiting for a clock.
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head            = mem[rd_ptr];
  assign out_instruction = out_valid ? head.instruction : '0;
  assign out_pc          = out_valid ? head.pc          : '0;

  // Pointers and occupancy. DEPTH is a power of two, so plain increment of a
  // PW-bit pointer wraps from DEPTH-1 back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. Stale entries left behind by pop or flush are never
  // visible because the output mux is gated by out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= '{instruction: in_instruction, pc: in_pc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_instruction;
  logic [WIDTH-1:0] in_pc;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_instruction;
  logic [WIDTH-1:0] out_pc;
  logic             out_ready;
  logic             flush;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .flush           (flush),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid       = 1'b0;
    in_instruction = '0;
    in_pc          = '0;
    out_ready      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic push_one(input logic [15:0] instr, input logic [15:0] pc);
    in_valid       = 1'b1;
    in_instruction = instr;
    in_pc          = pc;
    out_ready      = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rcv;
    idle_inputs();
    reset = 1'b1;
    #2;
    // Reset state, before any clock edge.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_instr", 32'(out_instruction), 32'd0);
    check("rst_out_pc",    32'(out_pc),    32'd0);
    // Push offered during reset is discarded.
    in_valid = 1'b1; in_instruction = 16'h7777;
    step();
    check("rst_push_ignored", 32'(count), 32'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Single push, 1-cycle latency, no bypass.
    in_valid = 1'b1; in_instruction = 16'h1234; in_pc = 16'h0000;
    check("nobypass_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("p1_out_valid", 32'(out_valid),       32'd1);
    check("p1_instr",     32'(out_instruction), 32'h1234);
    check("p1_pc",        32'(out_pc),          32'h0000);
    check("p1_count",     32'(count),           32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("p1_drained_empty", 32'(empty), 32'd1);

    // Fill to full, fifth push dropped, then drain in order.
    for (int i = 0; i < 4; i++) push_one(16'hA000 + 16'(i), 16'h0100 + 16'(i));
    check("fill_count",    32'(count),    32'd4);
    check("fill_full",     32'(full),     32'd1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    push_one(16'hA004, 16'h0104);
    check("fill_drop_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_instr_%0d", i), 32'(out_instruction), 32'hA000 + i);
      check($sformatf("drain_pc_%0d", i),    32'(out_pc),          32'h0100 + i);
      step();
    end
    check("drain_empty",     32'(empty),           32'd1);
    check("drain_out_instr", 32'(out_instruction), 32'd0);
    // Pop while empty changes nothing.
    step();
    check("empty_pop_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Simultaneous push and pop at count=2.
    push_one(16'hD000, 16'h0200);
    push_one(16'hD001, 16'h0201);
    in_valid = 1'b1; in_instruction = 16'hD002; in_pc = 16'h0202; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("pp_count", 32'(count),           32'd2);
    check("pp_head",  32'(out_instruction), 32'hD001);
    step();
    check("pp_next",  32'(out_instruction), 32'hD002);
    check("pp_next_pc", 32'(out_pc),        32'h0202);
    step();
    check("pp_empty", 32'(empty), 32'd1);

    // Continuous streaming of 10 words across several pointer wraps.
    rcv = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      in_valid       = (t < 10);
      in_instruction = 16'hB000 + 16'(t);
      in_pc          = 16'h0300 + 16'(t);
      if (out_valid) begin
        check($sformatf("stream_%0d", rcv), 32'(out_instruction), 32'hB000 + rcv);
        rcv++;
      end
      step();
    end
    in_valid = 1'b0;
    check("stream_received", 32'(rcv),   32'd10);
    check("stream_empty",    32'(empty), 32'd1);
    out_ready = 1'b0;

    // Flush beats same-cycle push and pop.
    for (int i = 0; i < 3; i++) push_one(16'hE000 + 16'(i), 16'h0400 + 16'(i));
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_instruction = 16'hC000; in_pc = 16'h0500; out_ready = 1'b1;
    step();
    idle_inputs();
    check("flush_count",     32'(count),     32'd0);
    check("flush_empty",     32'(empty),     32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    push_one(16'hF000, 16'h0600);
    check("post_flush_count", 32'(count),           32'd1);
    check("post_flush_head",  32'(out_instruction), 32'hF000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset between edges at count=2.
    push_one(16'h5000, 16'h0700);
    push_one(16'h5001, 16'h0701);
    check("pre_areset_count", 32'(count), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    check("areset_count",     32'(count),     32'd0);
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_in_ready",  32'(in_ready),  32'd1);
    #1;
    reset = 1'b0;
    push_one(16'h6000, 16'h0800);
    check("after_areset_count", 32'(count),           32'd1);
    check("after_areset_head",  32'(out_instruction), 32'h6000);
    check("after_areset_pc",    32'(out_pc),          32'h0800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-002 SHALL provide parameter WIDTH, default 16, meaning the width of the instruction and the PC fields.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the instruction memory presents a fetched word.
REQ-006 SHALL have port in_instruction, input, WIDTH bits: the fetched instruction word.
REQ-007 SHALL have port in_pc, input, WIDTH bits: the program-counter value the word was fetched from.
REQ-008 SHALL have port in_ready, output, 1 bit: the queue accepts a push this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: the head entry is presented to the instruction decoder.
REQ-010 SHALL have port out_instruction, output, WIDTH bits: the head instruction.
REQ-011 SHALL have port out_pc, output, WIDTH bits: the PC of the head instruction.
REQ-012 SHALL have port out_ready, input, 1 bit: the decoder consumes the head this cycle.
REQ-013 SHALL have port flush, input, 1 bit: discard all entries (jump or return taken).
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of valid entries.
REQ-015 SHALL have ports full and empty, output, 1 bit each: full = (count==DEPTH), empty = (count==0).

Function
REQ-016 SHALL store entries in a circular buffer with write and read pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-017 SHALL define push = in_valid && in_ready, with in_ready = !full as a combinational output.
REQ-018 SHALL define pop = out_valid && out_ready, with out_valid = !empty.
REQ-019 SHALL, on push, write {in_instruction, in_pc} at the write pointer and advance the write pointer by 1.
REQ-020 SHALL, on pop, advance the read pointer by 1.
REQ-021 SHALL, on simultaneous push and pop with count>0, perform both operations and leave count unchanged.
REQ-022 SHALL provide no bypass: a word pushed into an empty queue appears on out_valid at the next rising edge (1-cycle latency).
REQ-023 SHALL drive out_instruction and out_pc from the head entry when out_valid=1 and as 0 when empty.
REQ-024 SHALL ignore in_valid while full: nothing is written, and no pointer or count changes.
REQ-025 SHALL ignore out_ready while empty: nothing changes.
REQ-026 SHALL give flush priority over push and pop: on a flush edge, pointers and count go to 0 and any same-cycle push or pop is discarded.
REQ-027 SHALL show empty=1 and out_valid=0 in the cycle after a flush; a push in the following cycle is accepted normally.
REQ-028 SHALL preserve FIFO order exactly, including across pointer wrap-around.
REQ-029 SHALL never let count exceed DEPTH or go below 0.

Reset
REQ-030 SHALL, while reset=1 and regardless of clk, clear pointers and count to 0 and storage to 0.
REQ-031 SHALL hold out_valid=0, out_instruction=0, out_pc=0, empty=1, full=0 and in_ready=1 while reset is asserted.
REQ-032 SHALL discard any in-flight push or pop when reset is asserted mid-operation; the first edge after reset deassertion behaves as from an empty queue.

Verification
REQ-033 SHALL cover this scenario: reset, then push 0x1234/pc 0x0000 with out_ready=0 -> next cycle out_valid=1, out_instruction=0x1234, out_pc=0x0000, count=1.
REQ-034 SHALL cover this scenario: push 5 words 0xA000..0xA004 with out_ready=0 -> count=4, full=1, in_ready=0, 0xA004 dropped; then drain -> outputs 0xA000..0xA003 in order, then empty=1.
REQ-035 SHALL cover this scenario: at count=2, push and pop in the same cycle -> count stays 2, head advances to the next entry.
REQ-036 SHALL cover this scenario: continuous push/pop for 10 words 0xB000..0xB009 -> all appear in order with no loss across at least 2 pointer wraps.
REQ-037 SHALL cover this scenario: at count=3, assert flush together with in_valid=1 (0xC000) and out_ready=1 -> next cycle count=0, empty=1, out_valid=0, and 0xC000 is not stored.
REQ-038 SHALL cover this scenario: assert reset asynchronously between clock edges at count=2 -> count=0 and out_valid=0 immediately, before the next rising edge.
